// File: rtl/beep_play_ctrl.sv
// Play/pause/idle controller for the melody buzzer stage: debounced keys, loop mode,
// and a note-position mirror that only advances on enabled cycles.
module beep_play_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned NOTE_TIME    = 15_000_000,
  parameter int unsigned SONG_NOTES   = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_play_n,
  input  logic       key_mode_n,
  output logic       en,
  output logic       paused,
  output logic       loop_mode,
  output logic [5:0] note_idx,
  output logic       song_done
);
  localparam int unsigned     DB_W      = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [23:0]     NOTE_LAST = 24'(NOTE_TIME - 1);
  localparam logic [5:0]      IDX_LAST  = 6'(SONG_NOTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  // Bit 0 is the play key, bit 1 the mode key.
  logic [1:0]      sync1_q, sync2_q, db_q, db_prev_q, armed_q, fill_q;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt_q [2];

  state_e      state_q, state_d;
  logic        loop_q, loop_d;
  logic [23:0] note_cnt_q, note_cnt_d;
  logic [5:0]  note_idx_q, note_idx_d;
  logic        note_last, song_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      db_prev_q <= '1;
      armed_q   <= '0;
      fill_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {key_mode_n, key_play_n};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      fill_q    <= {fill_q[0], 1'b1};
      // A key only arms once a real released sample has passed the synchronizer,
      // so a key held through reset cannot fire until it is released and re-pressed.
      armed_q   <= armed_q | ({2{fill_q[1]}} & sync2_q);
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      loop_q     <= 1'b0;
      note_cnt_q <= '0;
      note_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      loop_q     <= loop_d;
      note_cnt_q <= note_cnt_d;
      note_idx_q <= note_idx_d;
    end
  end

  always_comb begin
    press      = db_prev_q & ~db_q & armed_q;
    state_d    = state_q;
    loop_d     = loop_q ^ press[1];
    note_cnt_d = note_cnt_q;
    note_idx_d = note_idx_q;
    en         = (state_q == S_PLAY);
    paused     = (state_q == S_PAUSE);
    note_last  = (note_cnt_q == NOTE_LAST);
    song_end   = en & note_last & (note_idx_q == IDX_LAST);
    song_done  = song_end;
    loop_mode  = loop_q;
    note_idx   = note_idx_q;

    if (en) begin
      if (note_last) begin
        note_cnt_d = '0;
        note_idx_d = (note_idx_q == IDX_LAST) ? '0 : note_idx_q + 6'd1;
      end else begin
        note_cnt_d = note_cnt_q + 24'd1;
      end
    end

    // Song end decides with the pre-toggle loop mode.
    unique case (state_q)
      S_IDLE:  if (press[0]) state_d = S_PLAY;
      S_PLAY: begin
        if (song_end)      state_d = !loop_q ? S_IDLE : (press[0] ? S_PAUSE : S_PLAY);
        else if (press[0]) state_d = S_PAUSE;
      end
      S_PAUSE: if (press[0]) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_beep_play_ctrl.sv
// Bench for beep_play_ctrl: directed scenarios plus random key activity, checked every
// cycle against a position/history based model of the controller.
module tb_beep_play_ctrl;
  localparam int D     = 4;
  localparam int NT    = 10;
  localparam int SN    = 3;
  localparam int TOTAL = NT * SN;
  localparam int MAXE  = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_play_n = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       en, paused, loop_mode, song_done;
  logic [5:0] note_idx;

  beep_play_ctrl #(.DEBOUNCE_CNT(D), .NOTE_TIME(NT), .SONG_NOTES(SN)) dut (
    .clk(clk), .rst(rst), .key_play_n(key_play_n), .key_mode_n(key_mode_n),
    .en(en), .paused(paused), .loop_mode(loop_mode), .note_idx(note_idx),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: raw key samples per edge since reset, accepted levels, and one song position.
  bit hist [0:1][0:MAXE-1];
  int k;
  bit m_db [2];
  int pend [2];
  int seen1 [2];
  int m_state;   // 0 idle, 1 play, 2 pause
  bit m_loop;
  int m_pos;     // enabled cycles into the song, 0..TOTAL-1
  bit m_valid = 1'b0;
  int en_cyc = 0;

  function automatic bit samp(int key, int j);
    if (j < 1) return 1'b1;
    return hist[key][j];
  endfunction

  always @(posedge clk) begin
    bit go [2];
    bit v, same, song_end_m;
    int nxt;
    if (rst) begin
      m_valid = 1'b1; k = 0; m_state = 0; m_loop = 1'b0; m_pos = 0;
      for (int i = 0; i < 2; i++) begin m_db[i] = 1'b1; pend[i] = -1; seen1[i] = -1; end
    end else if (m_valid) begin
      k++;
      if (k >= MAXE) begin
        $display("FAIL model_history_overflow: edge %0d limit %0d", k, MAXE);
        $fatal(1);
      end
      hist[0][k] = key_play_n;
      hist[1][k] = key_mode_n;
      for (int i = 0; i < 2; i++) begin
        go[i] = (pend[i] == k) && (seen1[i] >= 1) && (seen1[i] <= k - 3);
        if (pend[i] == k) pend[i] = -1;
        // accept a level after D consecutive equal synchronized samples
        v = samp(i, k - 2);
        same = 1'b1;
        for (int j = k - 3; j >= k - D - 1; j--) if (samp(i, j) != v) same = 1'b0;
        if (same && v != m_db[i]) begin
          m_db[i] = v;
          if (!v) pend[i] = k + 1;
        end
        if (seen1[i] < 0 && hist[i][k]) seen1[i] = k;
      end
      song_end_m = (m_state == 1) && (m_pos == TOTAL - 1);
      nxt = m_state;
      case (m_state)
        0: if (go[0]) nxt = 1;
        2: if (go[0]) nxt = 1;
        default: begin
          if (song_end_m) nxt = m_loop ? (go[0] ? 2 : 1) : 0;
          else if (go[0]) nxt = 2;
        end
      endcase
      if (m_state == 1) m_pos = (m_pos + 1) % TOTAL;
      if (go[1]) m_loop = !m_loop;
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    bit e_en, e_pa, e_sd;
    int e_idx;
    if (en === 1'b1) en_cyc++;
    if (m_valid) begin
      e_en  = (m_state == 1);
      e_pa  = (m_state == 2);
      e_idx = m_pos / NT;
      e_sd  = e_en && (m_pos == TOTAL - 1);
      n_cmp++;
      if (en !== e_en || paused !== e_pa || loop_mode !== m_loop ||
          note_idx !== 6'(e_idx) || song_done !== e_sd) begin
        n_err++;
        $display("FAIL cycle_model t=%0t: got en=%b paused=%b loop=%b idx=%0d done=%b, need en=%b paused=%b loop=%b idx=%0d done=%b",
                 $time, en, paused, loop_mode, note_idx, song_done, e_en, e_pa, m_loop, e_idx, e_sd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d need %0d", name, got, exp);
    end
  endtask

  task automatic set_key(int which, bit v);
    if (which == 0) key_play_n = v;
    else key_mode_n = v;
  endtask

  initial begin
    int n, base, pulses;
    bit seen;

    // 1: reset
    repeat (3) tick();
    check("t1_en", en, 0);
    check("t1_paused", paused, 0);
    check("t1_loop", loop_mode, 0);
    check("t1_idx", note_idx, 0);
    check("t1_done", song_done, 0);
    rst = 1'b0;
    repeat (5) tick();

    // 2: bounce, then a stable press
    for (int i = 0; i < 10; i++) begin key_play_n = ~key_play_n; repeat (2) tick(); end
    check("t2_no_play_on_bounce", en, 0);
    key_play_n = 1'b0;
    n = 0;
    while (!en && n < 20) begin tick(); n++; end
    check("t2_play_latency", n, 7);
    repeat (3) tick();
    key_play_n = 1'b1;
    n = 0;
    while (en && n < 80) begin tick(); n++; end
    check("t2_back_to_idle", en, 0);

    // 3: full song without loop
    repeat (5) tick();
    base = en_cyc; pulses = 0; seen = 1'b0;
    key_play_n = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i == 8) key_play_n = 1'b1;
      if (song_done) pulses++;
      if (en) seen = 1'b1;
      if (seen && !en) break;
    end
    check("t3_enabled_cycles", en_cyc - base, 30);
    check("t3_done_pulses", pulses, 1);
    check("t3_idx_after", note_idx, 0);

    // 4: pause after 12 enabled cycles, then resume
    repeat (5) tick();
    key_play_n = 1'b0;
    n = 0;
    while (!en && n < 20) begin tick(); n++; end
    base = en_cyc;
    key_play_n = 1'b1;
    repeat (5) tick();
    key_play_n = 1'b0;
    n = 0;
    while (!paused && n < 20) begin tick(); n++; end
    check("t4_paused", paused, 1);
    check("t4_cycles_at_pause", en_cyc - base, 12);
    check("t4_idx_at_pause", note_idx, 1);
    repeat (3) tick();
    key_play_n = 1'b1;
    repeat (10) tick();
    check("t4_idx_held", note_idx, 1);
    key_play_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i == 8) key_play_n = 1'b1;
      if (song_done) seen = 1'b1;
      if (seen && !en) break;
    end
    check("t4_total_enabled", en_cyc - base, 30);

    // 5: loop mode, then pause exactly on a song end
    repeat (5) tick();
    key_mode_n = 1'b0;
    repeat (8) tick();
    key_mode_n = 1'b1;
    repeat (8) tick();
    check("t5_loop_on", loop_mode, 1);
    key_play_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 75; i++) begin
      tick();
      if (i == 8) key_play_n = 1'b1;
      if (song_done) pulses++;
    end
    check("t5_still_playing", en, 1);
    check("t5_two_pulses", pulses, 2);
    n = 0;
    while (!song_done && n < 40) begin tick(); n++; end
    repeat (24) tick();
    key_play_n = 1'b0;
    repeat (7) tick();
    check("t5_pause_on_end", paused, 1);
    check("t5_idx_zero", note_idx, 0);
    repeat (3) tick();
    key_play_n = 1'b1;
    repeat (8) tick();

    // 6: reset mid-play with the play key held down
    key_play_n = 1'b0;
    repeat (8) tick();
    key_play_n = 1'b1;
    n = 0;
    while (note_idx != 6'd2 && n < 60) begin tick(); n++; end
    check("t6_reach_idx2", note_idx, 2);
    key_play_n = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_en", en, 0);
    check("t6_idx", note_idx, 0);
    check("t6_loop", loop_mode, 0);
    repeat (20) tick();
    check("t6_held_key_ignored", en, 0);
    key_play_n = 1'b1;
    repeat (8) tick();
    key_play_n = 1'b0;
    n = 0;
    while (!en && n < 20) begin tick(); n++; end
    check("t6_repress_latency", n, 7);
    repeat (3) tick();
    key_play_n = 1'b1;

    // random key activity, occasional resets
    for (int it = 0; it < 60; it++) begin
      int which;
      which = $urandom_range(0, 1);
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        set_key(which, 1'b0);
        repeat ($urandom_range(1, 3)) tick();
        set_key(which, 1'b1);
        repeat ($urandom_range(1, 3)) tick();
      end
      set_key(which, 1'b0);
      repeat ($urandom_range(1, 10)) tick();
      set_key(which, 1'b1);
      repeat ($urandom_range(0, 40)) tick();
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
